// File: rtl/axis_n_to_one_pkt_mux.sv
// axis_n_to_one_pkt_mux: packet-locked N:1 AXI-Stream mux with registered output stage
module axis_n_to_one_pkt_mux #(
  parameter int DataWidth = 32,
  parameter int NumCh = 4,
  parameter int SelWidth = 2,
  parameter bit ArbMode = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SelWidth-1:0]        sel,
  input  logic [NumCh*DataWidth-1:0] s_axis_tdata,
  input  logic [NumCh-1:0]           s_axis_tvalid,
  output logic [NumCh-1:0]           s_axis_tready,
  input  logic [NumCh-1:0]           s_axis_tlast,
  output logic [DataWidth-1:0]       m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       busy,
  output logic [SelWidth-1:0]        grant_ch
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nxt;
  logic [SelWidth-1:0] lock_ch, rr_ptr, rr_next, cand;
  logic cand_ok, can_load, accept, found;
  int idx;
  assign busy = state == LOCKED;
  assign can_load = ~m_axis_tvalid | m_axis_tready;
  always_comb begin
    rr_next = 32'(rr_ptr) >= NumCh - 1 ? '0 : rr_ptr + 1'b1;
    cand = rr_next;
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < NumCh; i++) begin
      idx = int'(rr_next) + i;
      idx = idx >= NumCh ? idx - NumCh : idx;
      if (!found && s_axis_tvalid[idx]) begin
        cand = SelWidth'(idx);
        found = 1'b1;
      end
    end
    cand = state == LOCKED ? lock_ch : (ArbMode ? cand : sel);
    cand_ok = state == LOCKED || ArbMode || 32'(sel) < NumCh;
    s_axis_tready = (can_load && cand_ok) ? NumCh'(1) << cand : '0;
    accept = |(s_axis_tvalid & s_axis_tready);
    state_nxt = accept ? (s_axis_tlast[cand] ? IDLE : LOCKED) : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lock_ch <= '0;
      rr_ptr <= SelWidth'(NumCh - 1);
      grant_ch <= '0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        m_axis_tdata <= s_axis_tdata[int'(cand)*DataWidth +: DataWidth];
        m_axis_tlast <= s_axis_tlast[cand];
        m_axis_tvalid <= 1'b1;
        lock_ch <= cand;
        grant_ch <= cand;
        if (s_axis_tlast[cand]) rr_ptr <= cand;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule
